alu_operand_loader: RTL

Upstream input stage for `compactALU`. It lets a user enter operand A, operand B and the operation select/carry-in one after another from shared board switches, using a single push button. The button is synchronised and debounced inside the block. Captured values are held on registered outputs that connect directly to the ALU inputs `A`, `B`, `select` and `cin`. A one-cycle `valid` pulse marks a complete operand set.

---
 rtl/alu_operand_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - debounced single-button operand loader feeding compactALU
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset
//   sw      in   [N] data switches, captured as A then B
//   op_sw   in   [3] operation select switches
//   cin_sw  in   carry-in switch
//   btn     in   raw asynchronous bouncing push button, high = pressed
//   A, B    out  [N] registered operands
//   select  out  [3] registered operation select
//   cin     out  registered carry-in
//   stage   out  [2] current FSM state, for the LEDs
//   valid   out  one-cycle pulse after a full operand set is captured
module alu_operand_loader #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic [2:0]   op_sw,
  input  logic         cin_sw,
  input  logic         btn,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [2:0]   select,
  output logic         cin,
  output logic [1:0]   stage,
  output logic         valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The increment that would make the count equal DEBOUNCE_CYCLES is the
  // one that accepts the new level, so compare against the value before it.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_B  = 2'd1;
  localparam logic [1:0] LOAD_OP = 2'd2;
  localparam logic [1:0] READY   = 2'd3;

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [2:0]    r_sel;
  logic          r_cin;
  logic          r_valid;

  // Button synchroniser, debouncer and press edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      // Any return to the accepted level restarts the stability count.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_db_q  <= r_db;
      // Only the rising edge of the debounced level is an event; releases are ignored.
      r_press <= r_db & ~r_db_q;
    end
  end

  // Operand capture FSM, one step per accepted press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_cin   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_press) begin
        case (r_state)
          LOAD_A: begin
            r_a     <= sw;
            r_state <= LOAD_B;
          end
          LOAD_B: begin
            r_b     <= sw;
            r_state <= LOAD_OP;
          end
          LOAD_OP: begin
            r_sel   <= op_sw;
            r_cin   <= cin_sw;
            r_valid <= 1'b1;
            r_state <= READY;
          end
          default: begin
            // Operands are kept until overwritten in the next round.
            r_state <= LOAD_A;
          end
        endcase
      end
    end
  end

  assign A      = r_a;
  assign B      = r_b;
  assign select = r_sel;
  assign cin    = r_cin;
  assign stage  = r_state;
  assign valid  = r_valid;

endmodule
